// File: rtl/vdp_pkg.sv
// vdp_pkg: shared line-buffer fill states and default sizing constants.
package vdp_pkg;

    localparam int LB_DATA_W = 32;
    localparam int LB_DEPTH  = 512;
    localparam int LB_CNT_W  = 16;

    typedef enum logic {
        LB_FILL = 1'b0,
        LB_FULL = 1'b1
    } lb_state_e;

endpackage

// File: rtl/lb_bank_ram.sv
// lb_bank_ram: one line bank, single write port and one registered read port.
module lb_bank_ram
    import vdp_pkg::*;
#(
    parameter  int DATA_W = LB_DATA_W,
    parameter  int DEPTH  = LB_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic              re_i,
    input  logic [AW-1:0]     ra_i,
    output logic [DATA_W-1:0] rd_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wa_i] <= wd_i;
        end
    end

    // Only the output register is reset; the array itself is never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (re_i) begin
            rd_q <= mem[ra_i];
        end
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/vdp_linebuffer.sv
// vdp_linebuffer: ping-pong line buffer between VDP fetch and VGA scan-out.
// Define LINEBUF_REPEAT_EN to add repeat_line (line_start without bank swap).
module vdp_linebuffer
    import vdp_pkg::*;
#(
    parameter  int DATA_W = LB_DATA_W,
    parameter  int DEPTH  = LB_DEPTH,
    parameter  int CNT_W  = LB_CNT_W,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_start,
`ifdef LINEBUF_REPEAT_EN
    input  logic              repeat_line,
`endif
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_adr,
    output logic [DATA_W-1:0] rd_dat,
    output logic              disp_bank,
    output logic              fill_done,
    output logic              underrun,
    output logic [CNT_W-1:0]  underrun_cnt
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vdp_linebuffer: DEPTH must be a power of two >= 2");
    end

    lb_state_e         state_q;
    logic [AW-1:0]     wr_ptr_q;
    logic              disp_bank_q;
    logic              fill_done_q;
    logic              underrun_q;
    logic [CNT_W-1:0]  ucnt_q;
    logic [CNT_W-1:0]  ucnt_d;
    logic              rd_sel_q;

    logic              accept;
    logic              final_wr;
    logic              complete;
    logic              ls_eff;
    logic              we0;
    logic              we1;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;

    assign wr_ready = (state_q == LB_FILL);
    assign accept   = wr_valid & wr_ready;
    assign final_wr = accept & (wr_last | (wr_ptr_q == AW'(DEPTH - 1)));
    assign complete = (state_q == LB_FULL) | final_wr;
    assign ucnt_d   = (&ucnt_q) ? ucnt_q : ucnt_q + 1'b1;

`ifdef LINEBUF_REPEAT_EN
    assign ls_eff = line_start & ~repeat_line;
`else
    assign ls_eff = line_start;
`endif

    // line_start wins over the same-cycle accept, but sees it via complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LB_FILL;
            wr_ptr_q    <= '0;
            disp_bank_q <= 1'b0;
            fill_done_q <= 1'b0;
            underrun_q  <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            underrun_q <= 1'b0;
            if (ls_eff) begin
                state_q     <= LB_FILL;
                wr_ptr_q    <= '0;
                fill_done_q <= 1'b0;
                if (complete) begin
                    disp_bank_q <= ~disp_bank_q;
                end else begin
                    underrun_q <= 1'b1;
                    ucnt_q     <= ucnt_d;
                end
            end else if (accept) begin
                if (final_wr) begin
                    state_q     <= LB_FULL;
                    fill_done_q <= 1'b1;
                end
                if (wr_ptr_q != AW'(DEPTH - 1)) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel_q <= 1'b0;
        end else if (rd_en) begin
            rd_sel_q <= disp_bank_q;
        end
    end

    // Fill always targets the bank that is not on display.
    assign we0 = accept & disp_bank_q;
    assign we1 = accept & ~disp_bank_q;

    lb_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (we0),
        .wa_i  (wr_ptr_q),
        .wd_i  (wr_data),
        .re_i  (rd_en),
        .ra_i  (rd_adr),
        .rd_o  (rd0)
    );

    lb_bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (we1),
        .wa_i  (wr_ptr_q),
        .wd_i  (wr_data),
        .re_i  (rd_en),
        .ra_i  (rd_adr),
        .rd_o  (rd1)
    );

    assign rd_dat       = rd_sel_q ? rd1 : rd0;
    assign disp_bank    = disp_bank_q;
    assign fill_done    = fill_done_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_vdp_linebuffer.sv
// tb_vdp_linebuffer: randomized self-checking bench with a line-level model.
module tb_vdp_linebuffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          line_start = 1'b0;
    logic          repeat_line = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_adr = '0;
    logic [DW-1:0] rd_dat;
    logic          disp_bank;
    logic          fill_done;
    logic          underrun;
    logic [CW-1:0] underrun_cnt;

    int total = 0;
    int bad = 0;

    // Model: two arrays of words, a count of words in the pending line,
    // whether that line is closed, and the displayed bank number.
    logic [DW-1:0] m_mem [2][DEPTH];
    bit            m_known [2][DEPTH];
    int            m_words;
    bit            m_full;
    bit            m_disp;
    bit            m_und;
    int            m_ucnt;
    logic [DW-1:0] m_rd;
    bit            m_rd_known;

    vdp_linebuffer #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_start   (line_start),
`ifdef LINEBUF_REPEAT_EN
        .repeat_line  (repeat_line),
`endif
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .rd_en        (rd_en),
        .rd_adr       (rd_adr),
        .rd_dat       (rd_dat),
        .disp_bank    (disp_bank),
        .fill_done    (fill_done),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: run exceeded time limit, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_words = 0;
        m_full = 0;
        m_disp = 0;
        m_und = 0;
        m_ucnt = 0;
        m_rd = '0;
        m_rd_known = 1;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                m_known[b][a] = 0;
    endtask

    task automatic model_edge();
        bit rep;
        rep = repeat_line;
        if (rd_en) begin
            m_rd_known = m_known[m_disp][rd_adr];
            m_rd = m_mem[m_disp][rd_adr];
        end
        if (wr_valid && !m_full) begin
            m_mem[!m_disp][m_words] = wr_data;
            m_known[!m_disp][m_words] = 1;
            m_words++;
            if (wr_last || m_words == DEPTH) m_full = 1;
        end
        m_und = 0;
        if (line_start && !rep) begin
            if (m_full) begin
                m_disp = !m_disp;
                m_full = 0;
            end else begin
                m_und = 1;
                if (m_ucnt < CMAX) m_ucnt++;
            end
            m_words = 0;
        end
    endtask

    task automatic idle();
        line_start = 0;
        repeat_line = 0;
        wr_valid = 0;
        wr_last = 0;
        rd_en = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic write_word(input logic [DW-1:0] d, input bit last);
        wr_valid = 1;
        wr_data = d;
        wr_last = last;
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) write_word($urandom, 0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
        total++;
        if (disp_bank !== 1'b0 || fill_done !== 1'b0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got disp=%b done=%b und=%b want 0 0 0",
                     disp_bank, fill_done, underrun);
        end
        total++;
        if (underrun_cnt !== '0 || rd_dat !== '0) begin
            bad++;
            $display("FAIL reset_data: got cnt=%0d rd=%h want 0 0", underrun_cnt, rd_dat);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_full_line();
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (wr_ready !== 1'b1) begin
                bad++;
                $display("FAIL full_ready_%0d: got %b want 1", i, wr_ready);
            end
            write_word(DW'(i), 0);
        end
        total++;
        if (wr_ready !== 1'b0 || fill_done !== 1'b1) begin
            bad++;
            $display("FAIL full_state: got ready=%b done=%b want 0 1", wr_ready, fill_done);
        end
        line_start = 1;
        tick();
        idle();
        total++;
        if (disp_bank !== 1'b1 || fill_done !== 1'b0 || underrun !== 1'b0) begin
            bad++;
            $display("FAIL full_swap: got disp=%b done=%b und=%b want 1 0 0",
                     disp_bank, fill_done, underrun);
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1;
            rd_adr = AW'(a);
            tick();
            total++;
            if (rd_dat !== DW'(a)) begin
                bad++;
                $display("FAIL full_read_%0d: got %h want %h", a, rd_dat, DW'(a));
            end
        end
        rd_en = 0;
        rd_adr = 0;
        tick();
        total++;
        if (rd_dat !== DW'(DEPTH - 1)) begin
            bad++;
            $display("FAIL read_hold: got %h want %h", rd_dat, DW'(DEPTH - 1));
        end
    endtask

    task automatic test_wr_last();
        logic [DW-1:0] d [3];
        bit old_disp;
        old_disp = disp_bank;
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            write_word(d[i], i == 2);
        end
        total++;
        if (wr_ready !== 1'b0 || fill_done !== 1'b1) begin
            bad++;
            $display("FAIL last_state: got ready=%b done=%b want 0 1", wr_ready, fill_done);
        end
        write_word($urandom, 0);
        total++;
        if (wr_ready !== 1'b0 || fill_done !== 1'b1) begin
            bad++;
            $display("FAIL last_extra: got ready=%b done=%b want 0 1", wr_ready, fill_done);
        end
        line_start = 1;
        tick();
        idle();
        total++;
        if (disp_bank !== !old_disp || underrun !== 1'b0) begin
            bad++;
            $display("FAIL last_swap: got disp=%b und=%b want %b 0",
                     disp_bank, underrun, !old_disp);
        end
        for (int a = 0; a < 3; a++) begin
            rd_en = 1;
            rd_adr = AW'(a);
            tick();
            total++;
            if (rd_dat !== d[a]) begin
                bad++;
                $display("FAIL last_read_%0d: got %h want %h", a, rd_dat, d[a]);
            end
        end
        idle();
    endtask

    task automatic test_underrun();
        logic [DW-1:0] d [DEPTH];
        bit old_disp;
        int old_cnt;
        old_disp = disp_bank;
        old_cnt = int'(underrun_cnt);
        for (int i = 0; i < 5; i++) write_word($urandom, 0);
        line_start = 1;
        tick();
        idle();
        total++;
        if (underrun !== 1'b1 || int'(underrun_cnt) !== old_cnt + 1) begin
            bad++;
            $display("FAIL und_pulse: got und=%b cnt=%0d want 1 %0d",
                     underrun, underrun_cnt, old_cnt + 1);
        end
        total++;
        if (disp_bank !== old_disp || wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL und_noswap: got disp=%b ready=%b want %b 1",
                     disp_bank, wr_ready, old_disp);
        end
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = $urandom;
            write_word(d[i], 0);
            if (i == 0) begin
                total++;
                if (underrun !== 1'b0) begin
                    bad++;
                    $display("FAIL und_oneshot: got %b want 0", underrun);
                end
            end
        end
        total++;
        if (fill_done !== 1'b1) begin
            bad++;
            $display("FAIL und_refill_done: got %b want 1", fill_done);
        end
        line_start = 1;
        tick();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1;
            rd_adr = AW'(a);
            tick();
            total++;
            if (rd_dat !== d[a]) begin
                bad++;
                $display("FAIL und_read_%0d: got %h want %h", a, rd_dat, d[a]);
            end
        end
        idle();
    endtask

    task automatic test_last_at_swap();
        logic [DW-1:0] x;
        bit old_disp;
        old_disp = disp_bank;
        for (int i = 0; i < 3; i++) write_word($urandom, 0);
        x = $urandom;
        wr_valid = 1;
        wr_data = x;
        wr_last = 1;
        line_start = 1;
        tick();
        idle();
        total++;
        if (disp_bank !== !old_disp || underrun !== 1'b0 || fill_done !== 1'b0) begin
            bad++;
            $display("FAIL same_swap: got disp=%b und=%b done=%b want %b 0 0",
                     disp_bank, underrun, fill_done, !old_disp);
        end
        rd_en = 1;
        rd_adr = 3;
        tick();
        idle();
        total++;
        if (rd_dat !== x) begin
            bad++;
            $display("FAIL same_read: got %h want %h", rd_dat, x);
        end
    endtask

`ifdef LINEBUF_REPEAT_EN
    task automatic test_repeat();
        bit old_disp;
        int old_cnt;
        for (int i = 0; i < DEPTH; i++) write_word($urandom, 0);
        old_disp = disp_bank;
        old_cnt = int'(underrun_cnt);
        line_start = 1;
        repeat_line = 1;
        tick();
        idle();
        total++;
        if (disp_bank !== old_disp || fill_done !== 1'b1 || underrun !== 1'b0 ||
            int'(underrun_cnt) !== old_cnt) begin
            bad++;
            $display("FAIL rep_full: got disp=%b done=%b und=%b cnt=%0d want %b 1 0 %0d",
                     disp_bank, fill_done, underrun, underrun_cnt, old_disp, old_cnt);
        end
        line_start = 1;
        tick();
        idle();
        for (int i = 0; i < 2; i++) write_word($urandom, 0);
        line_start = 1;
        repeat_line = 1;
        tick();
        idle();
        total++;
        if (underrun !== 1'b0 || fill_done !== 1'b0) begin
            bad++;
            $display("FAIL rep_partial: got und=%b done=%b want 0 0", underrun, fill_done);
        end
        for (int i = 0; i < DEPTH - 2; i++) write_word($urandom, 0);
        total++;
        if (fill_done !== 1'b1) begin
            bad++;
            $display("FAIL rep_keep_ptr: got done=%b want 1", fill_done);
        end
    endtask
`endif

    task automatic test_saturate();
        idle();
        for (int i = 0; i < CMAX + 4; i++) begin
            line_start = 1;
            tick();
            idle();
            total++;
            if (int'(underrun_cnt) !== m_ucnt || underrun !== 1'b1) begin
                bad++;
                $display("FAIL sat_step_%0d: got cnt=%0d und=%b want %0d 1",
                         i, underrun_cnt, underrun, m_ucnt);
            end
        end
        total++;
        if (underrun_cnt !== CW'(CMAX)) begin
            bad++;
            $display("FAIL sat_max: got %0d want %0d", underrun_cnt, CMAX);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data = $urandom;
            wr_last = ($urandom_range(0, 7) == 0);
            line_start = ($urandom_range(0, 9) == 0);
            rd_en = ($urandom_range(0, 1) == 1);
            rd_adr = AW'($urandom_range(0, DEPTH - 1));
`ifdef LINEBUF_REPEAT_EN
            repeat_line = ($urandom_range(0, 3) == 0);
`endif
            tick();
            total++;
            if (wr_ready !== !m_full || fill_done !== m_full || disp_bank !== m_disp) begin
                bad++;
                $display("FAIL rnd_state_%0d: got ready=%b done=%b disp=%b want %b %b %b",
                         c, wr_ready, fill_done, disp_bank, !m_full, m_full, m_disp);
            end
            total++;
            if (underrun !== m_und || int'(underrun_cnt) !== m_ucnt) begin
                bad++;
                $display("FAIL rnd_und_%0d: got und=%b cnt=%0d want %b %0d",
                         c, underrun, underrun_cnt, m_und, m_ucnt);
            end
            if (m_rd_known) begin
                total++;
                if (rd_dat !== m_rd) begin
                    bad++;
                    $display("FAIL rnd_rd_%0d: got %h want %h", c, rd_dat, m_rd);
                end
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_line();
        test_wr_last();
        test_underrun();
        test_last_at_swap();
`ifdef LINEBUF_REPEAT_EN
        test_repeat();
`endif
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
